// File: rtl/mem_pkg.sv
// Shared types and defaults for the backing-store controller.
// The init pattern places the address in the upper half of a word and its complement in the lower half.
package mem_pkg;

    localparam int unsigned MEM_ADDR_W  = 4;
    localparam int unsigned MEM_DATA_W  = 8;
    localparam int unsigned MEM_LATENCY = 4;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        RESP
    } mem_state_t;

    // Result is 2*addr_w bits wide, right-aligned; callers truncate or zero-pad it to DATA_W.
    function automatic logic [63:0] init_pattern(input int unsigned idx, input int unsigned addr_w);
        logic [63:0] mask;
        logic [63:0] a;
        mask = (64'd1 << addr_w) - 64'd1;
        a    = 64'(idx) & mask;
        return (a << addr_w) | (~a & mask);
    endfunction

endpackage

// File: rtl/mem_lat_timer.sv
// Access-latency timer: starts at zero on i_start and pulses o_expire
// in the cycle where the count reaches LATENCY-1.
module mem_lat_timer
    import mem_pkg::*;
#(
    parameter int unsigned LATENCY = MEM_LATENCY
) (
    input  logic clk,
    input  logic rst,
    input  logic i_start,
    output logic o_busy,
    output logic o_expire
);

    localparam logic [3:0] LAST = 4'(LATENCY - 1);

    logic [3:0] r_cnt;
    logic       r_busy;

    assign o_busy   = r_busy;
    assign o_expire = r_busy && (r_cnt == LAST);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt  <= '0;
            r_busy <= 1'b0;
        end else if (i_start) begin
            r_cnt  <= '0;
            r_busy <= 1'b1;
        end else if (r_busy) begin
            if (o_expire) begin
                r_busy <= 1'b0;
            end else begin
                r_cnt <= r_cnt + 4'd1;
            end
        end
    end

endmodule

// File: rtl/main_mem_ctrl.sv
// Backing-store controller behind the cache: one request at a time,
// fixed latency, single-cycle done pulse, saturating read/write counters.
module main_mem_ctrl
    import mem_pkg::*;
#(
    parameter int unsigned ADDR_W  = MEM_ADDR_W,
    parameter int unsigned DATA_W  = MEM_DATA_W,
    parameter int unsigned LATENCY = MEM_LATENCY
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              mem_req_valid,
    input  logic              mem_req_rw,
    input  logic [ADDR_W-1:0] mem_req_addr,
    input  logic [DATA_W-1:0] mem_req_datain,
    output logic              mem_req_ready,
    output logic              mem_done,
    output logic [DATA_W-1:0] mem_req_dataout,
    output logic [15:0]       mem_rd_count,
    output logic [15:0]       mem_wr_count
);

    localparam int unsigned DEPTH = 2 ** ADDR_W;

    mem_state_t r_state;
    mem_state_t w_next;

    logic              r_rw;
    logic [ADDR_W-1:0] r_addr;
    logic [DATA_W-1:0] r_data;
    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [DATA_W-1:0] r_dout;
    logic [15:0]       r_rd_count;
    logic [15:0]       r_wr_count;

    logic w_accept;
    logic w_busy;
    logic w_expire;
    logic w_commit;

    assign w_accept = (r_state == IDLE) && mem_req_valid;
    assign w_commit = (r_state == WAIT) && w_busy && w_expire;

    mem_lat_timer #(
        .LATENCY (LATENCY)
    ) u_timer (
        .clk      (clk),
        .rst      (rst),
        .i_start  (w_accept),
        .o_busy   (w_busy),
        .o_expire (w_expire)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next        = r_state;
        mem_req_ready = 1'b0;
        mem_done      = 1'b0;
        case (r_state)
            IDLE: begin
                mem_req_ready = 1'b1;
                if (mem_req_valid) begin
                    w_next = WAIT;
                end
            end
            WAIT: begin
                if (w_expire) begin
                    w_next = RESP;
                end
            end
            RESP: begin
                mem_done = 1'b1;
                w_next   = IDLE;
            end
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rw   <= 1'b0;
            r_addr <= '0;
            r_data <= '0;
        end else if (w_accept) begin
            r_rw   <= mem_req_rw;
            r_addr <= mem_req_addr;
            r_data <= mem_req_datain;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                r_mem[i] <= DATA_W'(init_pattern(i, ADDR_W));
            end
        end else if (w_commit && r_rw) begin
            r_mem[r_addr] <= r_data;
        end
    end

    // Read data and counters update only on the WAIT->RESP edge; dout holds otherwise.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_dout     <= '0;
            r_rd_count <= '0;
            r_wr_count <= '0;
        end else if (w_commit) begin
            if (r_rw) begin
                if (r_wr_count != 16'hFFFF) begin
                    r_wr_count <= r_wr_count + 16'd1;
                end
            end else begin
                r_dout <= r_mem[r_addr];
                if (r_rd_count != 16'hFFFF) begin
                    r_rd_count <= r_rd_count + 16'd1;
                end
            end
        end
    end

    assign mem_req_dataout = r_dout;
    assign mem_rd_count    = r_rd_count;
    assign mem_wr_count    = r_wr_count;

endmodule

// File: tb/tb_main_mem_ctrl.sv
// Randomized self-checking bench for main_mem_ctrl against an array/counter reference model.
module tb_main_mem_ctrl;

    localparam int unsigned LAT = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic        valid = 1'b0;
    logic        rw    = 1'b0;
    logic [3:0]  addr  = '0;
    logic [7:0]  din   = '0;
    logic        ready;
    logic        done;
    logic [7:0]  dout;
    logic [15:0] rdc;
    logic [15:0] wrc;

    logic        v1  = 1'b0;
    logic        rw1 = 1'b0;
    logic [3:0]  a1  = '0;
    logic [7:0]  d1  = '0;
    logic        ready1;
    logic        done1;
    logic [7:0]  dout1;
    logic [15:0] rdc1;
    logic [15:0] wrc1;

    main_mem_ctrl #(.ADDR_W(4), .DATA_W(8), .LATENCY(LAT)) dut (
        .clk             (clk),
        .rst             (rst),
        .mem_req_valid   (valid),
        .mem_req_rw      (rw),
        .mem_req_addr    (addr),
        .mem_req_datain  (din),
        .mem_req_ready   (ready),
        .mem_done        (done),
        .mem_req_dataout (dout),
        .mem_rd_count    (rdc),
        .mem_wr_count    (wrc)
    );

    main_mem_ctrl #(.ADDR_W(4), .DATA_W(8), .LATENCY(1)) dut1 (
        .clk             (clk),
        .rst             (rst),
        .mem_req_valid   (v1),
        .mem_req_rw      (rw1),
        .mem_req_addr    (a1),
        .mem_req_datain  (d1),
        .mem_req_ready   (ready1),
        .mem_done        (done1),
        .mem_req_dataout (dout1),
        .mem_rd_count    (rdc1),
        .mem_wr_count    (wrc1)
    );

    int n_checks = 0;
    int n_fail   = 0;

    logic [7:0]  m_mem [16];
    logic [7:0]  m_dout;
    int unsigned m_rd;
    int unsigned m_wr;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 16; i++) begin
            logic [3:0] a;
            a        = 4'(i);
            m_mem[i] = {a, ~a};
        end
        m_dout = '0;
        m_rd   = 0;
        m_wr   = 0;
    endtask

    task automatic check_outputs(input string tag, input logic exp_ready, input logic exp_done);
        check({tag, "_ready"}, 32'(ready), 32'(exp_ready));
        check({tag, "_done"},  32'(done),  32'(exp_done));
        check({tag, "_dout"},  32'(dout),  32'(m_dout));
        check({tag, "_rdcnt"}, 32'(rdc),   m_rd);
        check({tag, "_wrcnt"}, 32'(wrc),   m_wr);
    endtask

    // Called just after a falling edge with the controller idle; returns at the falling edge
    // of the first idle cycle. With hold set, valid stays high and inputs churn throughout.
    task automatic do_txn(input logic t_rw, input logic [3:0] t_addr, input logic [7:0] t_data,
                          input logic hold);
        valid = 1'b1;
        rw    = t_rw;
        addr  = t_addr;
        din   = t_data;
        check("accept_ready", 32'(ready), 32'd1);
        @(posedge clk);
        for (int k = 1; k <= int'(LAT) + 1; k++) begin
            @(negedge clk);
            if (!hold) valid = 1'b0;
            rw   = 1'($urandom);
            addr = 4'($urandom);
            din  = 8'($urandom);
            if (k == int'(LAT) + 1) begin
                if (t_rw) begin
                    m_mem[t_addr] = t_data;
                    if (m_wr < 32'hFFFF) m_wr++;
                end else begin
                    m_dout = m_mem[t_addr];
                    if (m_rd < 32'hFFFF) m_rd++;
                end
                check_outputs("resp", 1'b0, 1'b1);
            end else begin
                check_outputs("wait", 1'b0, 1'b0);
            end
        end
        @(negedge clk);
        check_outputs("idle", 1'b1, 1'b0);
        if (!hold) valid = 1'b0;
    endtask

    task automatic lat1_txn(input logic t_rw, input logic [3:0] t_addr, input logic [7:0] t_data,
                            input logic [7:0] exp_dout, input logic [15:0] exp_rd,
                            input logic [15:0] exp_wr);
        v1  = 1'b1;
        rw1 = t_rw;
        a1  = t_addr;
        d1  = t_data;
        @(posedge clk);
        @(negedge clk);
        v1 = 1'b0;
        check("lat1_wait_done",  32'(done1),  32'd0);
        check("lat1_wait_ready", 32'(ready1), 32'd0);
        @(negedge clk);
        check("lat1_resp_done",  32'(done1),  32'd1);
        check("lat1_resp_dout",  32'(dout1),  32'(exp_dout));
        check("lat1_resp_rdcnt", 32'(rdc1),   32'(exp_rd));
        check("lat1_resp_wrcnt", 32'(wrc1),   32'(exp_wr));
        @(negedge clk);
        check("lat1_idle_ready", 32'(ready1), 32'd1);
        check("lat1_idle_done",  32'(done1),  32'd0);
    endtask

    initial begin
        model_reset();
        @(negedge clk);
        check_outputs("reset", 1'b1, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check_outputs("post_reset", 1'b1, 1'b0);

        do_txn(1'b0, 4'hA, 8'h00, 1'b0);
        check("read_A", 32'(dout), 32'h0000_00A5);

        do_txn(1'b1, 4'hB, 8'hC0, 1'b0);
        do_txn(1'b0, 4'hB, 8'h00, 1'b0);
        check("read_B_written", 32'(dout), 32'h0000_00C0);

        // Back-to-back with valid held: each accept lands exactly LAT+2 cycles after the last.
        do_txn(1'b0, 4'h5, 8'h00, 1'b1);
        do_txn(1'b1, 4'h6, 8'h5A, 1'b1);
        do_txn(1'b0, 4'h6, 8'h00, 1'b0);

        valid = 1'b1;
        rw    = 1'b1;
        addr  = 4'h2;
        din   = 8'h77;
        @(posedge clk);
        @(negedge clk);
        valid = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        #1;
        model_reset();
        check_outputs("rst_mid_wait", 1'b1, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        for (int k = 0; k < int'(LAT) + 2; k++) begin
            @(negedge clk);
            check_outputs("after_abort", 1'b1, 1'b0);
        end
        do_txn(1'b0, 4'h2, 8'h00, 1'b0);
        check("read_2_after_abort", 32'(dout), 32'h0000_002D);

        do_txn(1'b0, 4'h3, 8'h00, 1'b0);
        do_txn(1'b1, 4'h4, 8'h99, 1'b0);
        check("dout_held_write", 32'(dout), 32'h0000_003C);
        @(negedge clk);
        check("dout_held_idle", 32'(dout), 32'h0000_003C);

        for (int n = 0; n < 40; n++) begin
            do_txn(1'($urandom), 4'($urandom), 8'($urandom), (n != 39) && 1'($urandom));
        end
        valid = 1'b0;

        force dut.r_rd_count = 16'hFFFE;
        #1;
        release dut.r_rd_count;
        m_rd = 32'h0000_FFFE;
        for (int n = 0; n < 3; n++) begin
            do_txn(1'b0, 4'($urandom), 8'h00, 1'b0);
        end
        check("rd_saturated", 32'(rdc), 32'h0000_FFFF);

        @(negedge clk);
        lat1_txn(1'b0, 4'hA, 8'h00, 8'hA5, 16'd1, 16'd0);
        lat1_txn(1'b1, 4'h7, 8'h3E, 8'hA5, 16'd1, 16'd1);
        lat1_txn(1'b0, 4'h7, 8'h00, 8'h3E, 16'd2, 16'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
